// File: rtl/colour_ctrl_pkg.sv
// Shared definitions for the colour-depth step scheduler: channel indices,
// depth limit and arbiter state encoding.
package colour_ctrl_pkg;

    localparam int         NUM_CH    = 3;
    localparam logic [1:0] RED       = 2'd0;
    localparam logic [1:0] GREEN     = 2'd1;
    localparam logic [1:0] BLUE      = 2'd2;
    localparam logic [2:0] DEPTH_MAX = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } arb_state_e;

    // Round-robin successor: red -> green -> blue -> red.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        logic [1:0] nxt;
        unique case (ch)
            RED:     nxt = GREEN;
            GREEN:   nxt = BLUE;
            default: nxt = RED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// One push-button: synchroniser, debounce, press detect and auto-repeat.
// Emits a single-cycle request pulse per press and per repeat interval.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic req_o
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax) + 1;

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            first_q, first_d;
    logic            req_q, req_d;

    always_comb begin
        level_d   = level_q;
        db_cnt_d  = '0;
        rpt_cnt_d = rpt_cnt_q;
        first_d   = first_q;
        req_d     = 1'b0;

        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // first_q selects the initial hold delay versus the steady repeat period
        if (level_d && !level_q) begin
            req_d     = 1'b1;
            rpt_cnt_d = '0;
            first_d   = 1'b1;
        end else if (level_q) begin
            if (first_q && rpt_cnt_q == RptW'(REPEAT_DELAY - 1)) begin
                req_d     = 1'b1;
                rpt_cnt_d = '0;
                first_d   = 1'b0;
            end else if (!first_q && rpt_cnt_q == RptW'(REPEAT_PERIOD - 1)) begin
                req_d     = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end else begin
            rpt_cnt_d = '0;
            first_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            first_q   <= 1'b1;
            req_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            first_q   <= first_d;
            req_q     <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/color_step_scheduler.sv
// Turns six raw buttons into one-at-a-time step strobes for the R/G/B depth
// counters, keeping shadow copies of the counters to saturate at 0 and 7.
module color_step_scheduler
    import colour_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned STEP_GAP        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btnUp,
    input  logic [2:0] btnDown,
    output logic [2:0] stepEn,
    output logic       stepDir,
    output logic [8:0] rgbShadow,
    output logic       busy
);

    localparam int unsigned GapW = $clog2(STEP_GAP) + 1;

    logic [2:0]      req_up, req_dn;
    logic [2:0]      pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
    logic [2:0]      valid_up, valid_dn, drop_up, drop_dn, clr_up, clr_dn;
    logic [2:0][2:0] shadow_q, shadow_d;
    arb_state_e      state_q, state_d;
    logic [1:0]      ptr_q, ptr_d, gnt_ch_q, gnt_ch_d;
    logic            gnt_dir_q, gnt_dir_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            sel_found, sel_dir;
    logic [1:0]      sel_ch, cand;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_up (
            .clk_i(clock),
            .rst_i(reset),
            .btn_i(btnUp[c]),
            .req_o(req_up[c])
        );
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_dn (
            .clk_i(clock),
            .rst_i(reset),
            .btn_i(btnDown[c]),
            .req_o(req_dn[c])
        );
    end

    // Conflicting or saturating requests are never eligible and are discarded.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            valid_up[c] = pend_up_q[c] & ~pend_dn_q[c] & (shadow_q[c] != DEPTH_MAX);
            valid_dn[c] = pend_dn_q[c] & ~pend_up_q[c] & (shadow_q[c] != 3'd0);
            drop_up[c]  = pend_up_q[c] & (pend_dn_q[c] | (shadow_q[c] == DEPTH_MAX));
            drop_dn[c]  = pend_dn_q[c] & (pend_up_q[c] | (shadow_q[c] == 3'd0));
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_ch    = ptr_q;
        sel_dir   = 1'b0;
        cand      = ptr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!sel_found && (valid_up[cand] || valid_dn[cand])) begin
                sel_found = 1'b1;
                sel_ch    = cand;
                sel_dir   = valid_up[cand];
            end
            cand = next_ch(cand);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_ch_d  = gnt_ch_q;
        gnt_dir_d = gnt_dir_q;
        gap_cnt_d = gap_cnt_q;
        shadow_d  = shadow_q;
        clr_up    = '0;
        clr_dn    = '0;
        stepEn    = '0;
        stepDir   = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d   = StGrant;
                    gnt_ch_d  = sel_ch;
                    gnt_dir_d = sel_dir;
                end
            end
            StGrant: begin
                busy             = 1'b1;
                stepEn[gnt_ch_q] = 1'b1;
                stepDir          = gnt_dir_q;
                shadow_d[gnt_ch_q] = gnt_dir_q ? shadow_q[gnt_ch_q] + 3'd1
                                               : shadow_q[gnt_ch_q] - 3'd1;
                clr_up[gnt_ch_q] = gnt_dir_q;
                clr_dn[gnt_ch_q] = ~gnt_dir_q;
                ptr_d            = next_ch(gnt_ch_q);
                gap_cnt_d        = '0;
                state_d          = StGap;
            end
            StGap: begin
                busy = 1'b1;
                if (gap_cnt_q == GapW'(STEP_GAP - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pend_up_d = (pend_up_q & ~drop_up & ~clr_up) | req_up;
    assign pend_dn_d = (pend_dn_q & ~drop_dn & ~clr_dn) | req_dn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= RED;
            gnt_ch_q  <= RED;
            gnt_dir_q <= 1'b0;
            gap_cnt_q <= '0;
            shadow_q  <= '0;
            pend_up_q <= '0;
            pend_dn_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_ch_q  <= gnt_ch_d;
            gnt_dir_q <= gnt_dir_d;
            gap_cnt_q <= gap_cnt_d;
            shadow_q  <= shadow_d;
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
        end
    end

    assign rgbShadow = shadow_q;

endmodule

// File: tb/tb_color_step_scheduler.sv
// Scoreboard bench: a press-level model predicts the sequence of step strobes
// and shadow levels; a monitor pops and compares every strobe the DUT issues.
module tb_color_step_scheduler;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int SG = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] btnUp, btnDown;
    logic [2:0] stepEn;
    logic       stepDir;
    logic [8:0] rgbShadow;
    logic       busy;

    color_step_scheduler #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .STEP_GAP       (SG)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btnUp    (btnUp),
        .btnDown  (btnDown),
        .stepEn   (stepEn),
        .stepDir  (stepDir),
        .rgbShadow(rgbShadow),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int dir;
    } step_t;

    step_t exp_q[$];
    int    pulse_cyc[$];
    int    sh[3];
    int    ptr;
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    step_t mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    always @(negedge clock) begin
        if (!reset && stepEn != 3'b000) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_step", int'(stepEn), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("step_channel", int'(stepEn), 1 << mon_e.ch);
                check("step_dir", int'(stepDir), mon_e.dir);
            end
        end
    end

    function automatic int model_rgb();
        return sh[2] * 64 + sh[1] * 8 + sh[0];
    endfunction

    // Requests produced by holding a clean press for h cycles.
    function automatic int nreq(input int h);
        return (h < RD) ? 1 : 2 + (h - RD) / RP;
    endfunction

    task automatic model_press(input int ch, input int dir, input int h);
        step_t s;
        for (int k = 0; k < nreq(h); k++) begin
            if ((dir == 1 && sh[ch] < 7) || (dir == 0 && sh[ch] > 0)) begin
                s.ch  = ch;
                s.dir = dir;
                exp_q.push_back(s);
                sh[ch] += (dir == 1) ? 1 : -1;
                ptr = (ch + 1) % 3;
            end
        end
    endtask

    // Simultaneous single up-presses: granted round-robin from the pointer.
    task automatic model_contend(input logic [2:0] mask);
        bit    pend[3];
        step_t s;
        for (int c = 0; c < 3; c++) pend[c] = mask[c] && sh[c] < 7;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 3; i++) begin
                int c = (ptr + i) % 3;
                if (pend[c]) begin
                    s.ch  = c;
                    s.dir = 1;
                    exp_q.push_back(s);
                    sh[c]++;
                    pend[c] = 0;
                    ptr = (c + 1) % 3;
                    break;
                end
            end
        end
    endtask

    task automatic press(input logic [2:0] up, input logic [2:0] dn, input int h);
        @(negedge clock);
        btnUp   = up;
        btnDown = dn;
        repeat (h) @(negedge clock);
        btnUp   = 3'b000;
        btnDown = 3'b000;
        repeat (30) @(negedge clock);
    endtask

    task automatic single_press(input int ch, input int dir, input int h);
        logic [2:0] m;
        m = 3'b001 << ch;
        model_press(ch, dir, h);
        press(dir ? m : 3'b000, dir ? 3'b000 : m, h);
        check("drain", exp_q.size(), 0);
        check("shadow", int'(rgbShadow), model_rgb());
    endtask

    task automatic do_reset();
        check("drain_at_reset", exp_q.size(), 0);
        reset = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 3; c++) sh[c] = 0;
        ptr = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, dir, h;
        bit seen;
        reset   = 1'b1;
        btnUp   = 3'b000;
        btnDown = 3'b000;
        for (int c = 0; c < 3; c++) sh[c] = 0;
        ptr = 0;
        #1;
        check("reset_stepEn", int'(stepEn), 0);
        check("reset_stepDir", int'(stepDir), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_shadow", int'(rgbShadow), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        single_press(0, 1, 10);
        check("single_press_shadow", int'(rgbShadow), 9'o001);
        single_press(1, 1, 10);

        // Bounce on green-down: never stable long enough to debounce.
        for (int i = 0; i < 6; i++) begin
            btnDown = (i % 2 == 0) ? 3'b010 : 3'b000;
            repeat (2) @(negedge clock);
        end
        btnDown = 3'b000;
        repeat (30) @(negedge clock);
        check("bounce_drain", exp_q.size(), 0);
        check("bounce_shadow", int'(rgbShadow), 9'o011);

        single_press(2, 1, 120);
        check("saturate_shadow", int'(rgbShadow), 9'o711);

        do_reset();
        pulse_cyc.delete();
        model_contend(3'b111);
        press(3'b111, 3'b000, 10);
        check("contend_drain", exp_q.size(), 0);
        check("contend_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("contend_gap1", pulse_cyc[1] - pulse_cyc[0], SG + 2);
            check("contend_gap2", pulse_cyc[2] - pulse_cyc[1], SG + 2);
        end
        check("contend_shadow", int'(rgbShadow), 9'o111);

        press(3'b010, 3'b010, 10);
        check("conflict_drain", exp_q.size(), 0);
        check("conflict_shadow", int'(rgbShadow), 9'o111);

        for (int n = 0; n < 20; n++) begin
            ch  = int'($urandom_range(2, 0));
            dir = int'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 0) h = int'($urandom_range(16, 6));
            else h = RD + RP * int'($urandom_range(3, 0)) + int'($urandom_range(4, 3));
            single_press(ch, dir, h);
        end

        do_reset();
        single_press(0, 1, 10);
        single_press(0, 1, 10);
        single_press(1, 1, 10);
        single_press(1, 1, 10);
        single_press(2, 1, 10);
        check("prebuild_shadow", int'(rgbShadow), 9'o122);
        model_press(0, 1, 10);
        @(negedge clock);
        btnUp = 3'b001;
        seen  = 0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clock);
            if (stepEn != 3'b000) seen = 1;
        end
        btnUp = 3'b000;
        check("reset_test_pulse_seen", int'(seen), 1);
        @(posedge clock);
        #2;
        check("gap_busy", int'(busy), 1);
        check("gap_shadow", int'(rgbShadow), 9'o123);
        check("gap_drain", exp_q.size(), 0);
        reset = 1'b1;
        #1;
        check("async_stepEn", int'(stepEn), 0);
        check("async_stepDir", int'(stepDir), 0);
        check("async_busy", int'(busy), 0);
        check("async_shadow", int'(rgbShadow), 0);
        exp_q.delete();
        for (int c = 0; c < 3; c++) sh[c] = 0;
        ptr = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        single_press(0, 1, 10);
        check("post_reset_shadow", int'(rgbShadow), 9'o001);

        check("final_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
